pcie_clk_seq: RTL and testbench
===============================

Name: pcie_clk_seq

Overview:
- Sequencer for the PCIe PIPE clock MMCM wrapper. Drives the MMCM reset and qualifies its lock output, then gates the PIPE clock enable.
- Performs PIPE rate changes (125/250 MHz pclk select) with a gate/switch/ungate handshake against per-lane GT rate-done signals.
- Runs on a free-running clock independent of the MMCM outputs; sits between the PCIe core reset logic and the MMCM wrapper.

Parameters:
- PCIE_LANE, 2, number of lanes (width of rate/select vectors)
- RST_CYCLES, 16, MMCM reset assertion length in clk_i cycles (>=1)
- LOCK_STABLE, 64, consecutive synchronized-lock cycles required before enabling pclk
- LOCK_TIMEOUT, 65535, max cycles waiting for lock per attempt
- RATE_TIMEOUT, 4095, max cycles waiting for all lanes' rate_done
- GATE_CYCLES, 8, cycles pipeclk_en_o is held low before and after a pclk_sel change
- MAX_RETRY, 3, lock attempts allowed before FAULT

Ports:
- clk_i  in  1  free-running sequencer clock
- rst_i  in  1  reset
- mmcm_lock_i  in  1  MMCM LOCKED, asynchronous; synchronized internally by 2 flops
- mmcm_rst_n_o  out  1  to MMCM wrapper rst_n_i
- pipeclk_en_o  out  1  to MMCM wrapper pipeclk_en_i
- pclk_sel_o  out  PCIE_LANE  to MMCM wrapper pclk_sel_i; all bits always equal
- rate_req_i  in  PCIE_LANE  requested per-lane rate (1 = 250 MHz), clk_i domain
- rate_done_i  in  PCIE_LANE  per-lane GT rate-change complete level, clk_i domain
- rate_ack_o  out  1  one-cycle pulse: rate change finished (success or revert)
- rate_err_o  out  1  sticky: last rate change timed out; cleared by next successful change
- ready_o  out  1  pclk running and stable
- fault_o  out  1  lock attempts exhausted
- retry_cnt_o  out  8  lock attempts since reset, saturating at 255

Behaviour:
- Reset:
  - Asynchronous, active-high on rst_i; one clock clk_i.
  - Reset values: mmcm_rst_n_o=0, pipeclk_en_o=0, pclk_sel_o=0, rate_ack_o=0, rate_err_o=0, ready_o=0, fault_o=0, retry_cnt_o=0.
  - State after reset: RST.
- lock_s is the synchronized lock signal (2-flop latency).
- States and transitions:
  - RST: mmcm_rst_n_o=0 for exactly RST_CYCLES cycles; increment retry_cnt_o on entry; then go to WAIT_LOCK.
  - WAIT_LOCK: mmcm_rst_n_o=1.
    - lock_s=1 goes to STABLE with a stable counter of 0.
    - LOCK_TIMEOUT cycles without lock: go to RST if retry_cnt_o<MAX_RETRY, else FAULT.
  - STABLE: counts consecutive lock_s=1 cycles.
    - Any lock_s=0 returns to WAIT_LOCK. The timeout counter is not reset.
    - When the count reaches LOCK_STABLE, go to RUN.
  - RUN: pipeclk_en_o=1 and ready_o=1 (both registered; asserted the cycle after entering RUN).
    - Rate change is triggered when all bits of rate_req_i are equal and differ from pclk_sel_o; go to GATE_OFF.
    - Mixed rate_req_i bits are ignored, and pclk_sel_o holds.
  - GATE_OFF: pipeclk_en_o=0 and ready_o=0 for GATE_CYCLES, then go to SWITCH.
  - SWITCH:
    - On entry, pclk_sel_o takes the requested value; the old value is latched.
    - Waits for &rate_done_i, then goes to GATE_ON and clears rate_err_o.
    - After RATE_TIMEOUT cycles: pclk_sel_o reverts to the latched old value, rate_err_o=1, go to GATE_ON.
  - GATE_ON: holds pipeclk_en_o=0 for GATE_CYCLES, then pulses rate_ack_o for one cycle and returns to RUN.
  - FAULT: mmcm_rst_n_o=0, pipeclk_en_o=0, fault_o=1. Exits only on rst_i.
- Lock loss:
  - lock_s=0 in RUN, GATE_OFF, SWITCH or GATE_ON immediately drops pipeclk_en_o and ready_o in the same registered update.
  - Goes to RST if retry_cnt_o<MAX_RETRY, else FAULT.
  - pclk_sel_o keeps its current value.
  - A pending rate change is abandoned with no rate_ack_o.
- retry_cnt_o is cleared only by rst_i; a successful lock does not clear it.
- A request arriving during GATE_OFF, SWITCH or GATE_ON is ignored until RUN; the request is re-evaluated there (level-based).
- Counters are sized with $clog2(max+1). A parameter of 0 is treated as 1.

Decomposition:
- Shared package pcie_clk_seq_pkg:
  - State enumeration.
  - Counter-width helper function.
  - Default timing constants.
- One sub-module: pcie_clk_seq_sync, a 2-flop ASYNC_REG synchronizer, reused for mmcm_lock_i.

Test Plan:
- Reset release, lock rises 40 cycles after mmcm_rst_n_o goes high and stays high: mmcm_rst_n_o low for 16 cycles; ready_o=pipeclk_en_o=1 after 64 stable cycles; retry_cnt_o=1.
- Lock never rises: 3 attempts of 16+65535 cycles; then fault_o=1, mmcm_rst_n_o=0, retry_cnt_o=3; rst_i clears all outputs.
- Lock glitches low for 1 cycle in STABLE: the stable count restarts, and ready_o is delayed by the full 64 cycles after the glitch.
- In RUN, rate_req_i=2'b11 and rate_done_i rises 100 cycles later:
  - pipeclk_en_o low 8 cycles before pclk_sel_o=2'b11.
  - pipeclk_en_o low 8 more cycles after done.
  - One rate_ack_o pulse, rate_err_o=0.
- In RUN, rate_req_i=2'b01: no state change and pclk_sel_o stays 2'b00. Then rate_req_i=2'b11 with rate_done_i held low: after 4095 cycles, pclk_sel_o=2'b00, rate_err_o=1, one rate_ack_o pulse.
- Lock drops during SWITCH: pipeclk_en_o=0 next cycle, RST entered, no rate_ack_o, retry_cnt_o increments.

Source files
------------

// File: rtl/pcie_clk_seq_pkg.sv
// Shared types, timing defaults and counter sizing for the PIPE clock sequencer.
package pcie_clk_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_GATE_OFF,
        ST_SWITCH,
        ST_GATE_ON,
        ST_FAULT
    } seq_state_e;

    localparam int DEF_PCIE_LANE    = 2;
    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_LOCK_STABLE  = 64;
    localparam int DEF_LOCK_TIMEOUT = 65535;
    localparam int DEF_RATE_TIMEOUT = 4095;
    localparam int DEF_GATE_CYCLES  = 8;
    localparam int DEF_MAX_RETRY    = 3;

    // A zero-length timing parameter behaves like a single cycle.
    function automatic int at_least_one(input int val);
        return (val < 1) ? 1 : val;
    endfunction

    // Width of a counter that must hold values up to max_val.
    function automatic int cnt_w(input int max_val);
        return $clog2(at_least_one(max_val) + 1);
    endfunction

endpackage

// File: rtl/pcie_clk_seq_sync.sv
// Two-flop synchronizer for single-bit asynchronous level signals.
module pcie_clk_seq_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

    // Shift the async level through two flops to settle metastability.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pcie_clk_seq.sv
// PIPE clock sequencer: MMCM reset/lock qualification, pclk gating and
// gate/switch/ungate rate changes against per-lane GT rate-done levels.
module pcie_clk_seq
    import pcie_clk_seq_pkg::*;
#(
    parameter int PCIE_LANE    = DEF_PCIE_LANE,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int RATE_TIMEOUT = DEF_RATE_TIMEOUT,
    parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mmcm_lock_i,
    output logic                 mmcm_rst_n_o,
    output logic                 pipeclk_en_o,
    output logic [PCIE_LANE-1:0] pclk_sel_o,
    input  logic [PCIE_LANE-1:0] rate_req_i,
    input  logic [PCIE_LANE-1:0] rate_done_i,
    output logic                 rate_ack_o,
    output logic                 rate_err_o,
    output logic                 ready_o,
    output logic                 fault_o,
    output logic [7:0]           retry_cnt_o
);

    localparam int RST_N  = at_least_one(RST_CYCLES);
    localparam int STAB_N = at_least_one(LOCK_STABLE);
    localparam int LTO_N  = at_least_one(LOCK_TIMEOUT);
    localparam int RTO_N  = at_least_one(RATE_TIMEOUT);
    localparam int GATE_N = at_least_one(GATE_CYCLES);
    localparam int MAXR_N = at_least_one(MAX_RETRY);

    localparam int RST_W  = cnt_w(RST_CYCLES);
    localparam int STAB_W = cnt_w(LOCK_STABLE);
    localparam int LTO_W  = cnt_w(LOCK_TIMEOUT);
    localparam int RTO_W  = cnt_w(RATE_TIMEOUT);
    localparam int GATE_W = cnt_w(GATE_CYCLES);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_N - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STAB_N - 1);
    localparam logic [LTO_W-1:0]  LTO_LAST  = LTO_W'(LTO_N - 1);
    localparam logic [RTO_W-1:0]  RTO_LAST  = RTO_W'(RTO_N - 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_N - 1);

    seq_state_e        state;
    logic [RST_W-1:0]  rst_cnt;
    logic [STAB_W-1:0] stable_cnt;
    logic [LTO_W-1:0]  lock_tmo_cnt;
    logic [RTO_W-1:0]  rate_tmo_cnt;
    logic [GATE_W-1:0] gate_cnt;
    logic              sel_q;
    logic              old_sel_q;
    logic              req_q;
    logic              lock_s;
    logic              retry_left;
    logic              req_uniform;
    logic              drop;

    pcie_clk_seq_sync u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (mmcm_lock_i),
        .q_o   (lock_s)
    );

    // Lanes always switch together, so one select bit fans out to every lane.
    assign pclk_sel_o  = {PCIE_LANE{sel_q}};
    assign req_uniform = (&rate_req_i) | ~(|rate_req_i);
    assign retry_left  = ({24'd0, retry_cnt_o} < 32'(MAXR_N));

    // A lock attempt is abandoned on lock-wait timeout or on lock loss once the clock is in use.
    always_comb begin
        drop = 1'b0;
        case (state)
            ST_WAIT_LOCK: drop = ~lock_s && (lock_tmo_cnt == LTO_LAST);
            ST_RUN, ST_GATE_OFF, ST_SWITCH, ST_GATE_ON: drop = ~lock_s;
            default: drop = 1'b0;
        endcase
    end

    // Main sequencer: all outputs are registered here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_RST;
            rst_cnt      <= '0;
            stable_cnt   <= '0;
            lock_tmo_cnt <= '0;
            rate_tmo_cnt <= '0;
            gate_cnt     <= '0;
            sel_q        <= 1'b0;
            old_sel_q    <= 1'b0;
            req_q        <= 1'b0;
            mmcm_rst_n_o <= 1'b0;
            pipeclk_en_o <= 1'b0;
            rate_ack_o   <= 1'b0;
            rate_err_o   <= 1'b0;
            ready_o      <= 1'b0;
            fault_o      <= 1'b0;
            retry_cnt_o  <= 8'd0;
        end else begin
            rate_ack_o <= 1'b0;
            if (drop) begin
                // Pending rate change is dropped silently; pclk_sel keeps its value.
                state        <= retry_left ? ST_RST : ST_FAULT;
                fault_o      <= ~retry_left;
                mmcm_rst_n_o <= 1'b0;
                pipeclk_en_o <= 1'b0;
                ready_o      <= 1'b0;
                rst_cnt      <= '0;
            end else begin
                case (state)
                    ST_RST: begin
                        mmcm_rst_n_o <= 1'b0;
                        pipeclk_en_o <= 1'b0;
                        ready_o      <= 1'b0;
                        // First RST cycle of each attempt counts the attempt.
                        if (rst_cnt == '0 && retry_cnt_o != 8'hFF)
                            retry_cnt_o <= retry_cnt_o + 8'd1;
                        if (rst_cnt == RST_LAST) begin
                            rst_cnt      <= '0;
                            lock_tmo_cnt <= '0;
                            mmcm_rst_n_o <= 1'b1;
                            state        <= ST_WAIT_LOCK;
                        end else begin
                            rst_cnt <= rst_cnt + RST_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_s) begin
                            stable_cnt <= '0;
                            state      <= ST_STABLE;
                        end else begin
                            lock_tmo_cnt <= lock_tmo_cnt + LTO_W'(1);
                        end
                    end
                    ST_STABLE: begin
                        // Glitch sends us back without clearing the attempt timeout.
                        if (!lock_s)
                            state <= ST_WAIT_LOCK;
                        else if (stable_cnt == STAB_LAST)
                            state <= ST_RUN;
                        else
                            stable_cnt <= stable_cnt + STAB_W'(1);
                    end
                    ST_RUN: begin
                        if (req_uniform && (rate_req_i[0] != sel_q)) begin
                            req_q        <= rate_req_i[0];
                            gate_cnt     <= '0;
                            pipeclk_en_o <= 1'b0;
                            ready_o      <= 1'b0;
                            state        <= ST_GATE_OFF;
                        end else begin
                            pipeclk_en_o <= 1'b1;
                            ready_o      <= 1'b1;
                        end
                    end
                    ST_GATE_OFF: begin
                        if (gate_cnt == GATE_LAST) begin
                            old_sel_q    <= sel_q;
                            sel_q        <= req_q;
                            rate_tmo_cnt <= '0;
                            state        <= ST_SWITCH;
                        end else begin
                            gate_cnt <= gate_cnt + GATE_W'(1);
                        end
                    end
                    ST_SWITCH: begin
                        if (&rate_done_i) begin
                            rate_err_o <= 1'b0;
                            gate_cnt   <= '0;
                            state      <= ST_GATE_ON;
                        end else if (rate_tmo_cnt == RTO_LAST) begin
                            sel_q      <= old_sel_q;
                            rate_err_o <= 1'b1;
                            gate_cnt   <= '0;
                            state      <= ST_GATE_ON;
                        end else begin
                            rate_tmo_cnt <= rate_tmo_cnt + RTO_W'(1);
                        end
                    end
                    ST_GATE_ON: begin
                        if (gate_cnt == GATE_LAST) begin
                            rate_ack_o <= 1'b1;
                            state      <= ST_RUN;
                        end else begin
                            gate_cnt <= gate_cnt + GATE_W'(1);
                        end
                    end
                    ST_FAULT: begin
                        mmcm_rst_n_o <= 1'b0;
                        pipeclk_en_o <= 1'b0;
                        ready_o      <= 1'b0;
                        fault_o      <= 1'b1;
                    end
                    default: state <= ST_RST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcie_clk_seq.sv
// Randomized bench for pcie_clk_seq; expectations are event latencies derived
// from the sequencing rules plus a tiny model of the selected rate.
module tb_pcie_clk_seq;

    localparam int LANES = 2;
    localparam int RST_C = 16;
    localparam int STAB  = 64;
    localparam int LTO   = 300;   // shortened lock timeout keeps fault runs brief
    localparam int RTO   = 400;   // shortened rate timeout
    localparam int GATE  = 8;
    localparam int MAXR  = 3;

    localparam int P_RSTN  = 0;
    localparam int P_READY = 1;
    localparam int P_EN    = 2;
    localparam int P_ACK   = 3;
    localparam int P_FAULT = 4;
    localparam int P_SEL   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lock = 1'b0;
    logic [LANES-1:0] req = '0;
    logic [LANES-1:0] done = '0;
    logic             rst_n;
    logic             en;
    logic [LANES-1:0] sel;
    logic             ack;
    logic             err;
    logic             ready;
    logic             fault;
    logic [7:0]       retry;

    int n_chk = 0;
    int n_err = 0;
    int ack_cnt = 0;
    bit sel_m = 1'b0;   // model: rate currently selected

    always #5 clk = ~clk;

    pcie_clk_seq #(
        .PCIE_LANE    (LANES),
        .RST_CYCLES   (RST_C),
        .LOCK_STABLE  (STAB),
        .LOCK_TIMEOUT (LTO),
        .RATE_TIMEOUT (RTO),
        .GATE_CYCLES  (GATE),
        .MAX_RETRY    (MAXR)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mmcm_lock_i  (lock),
        .mmcm_rst_n_o (rst_n),
        .pipeclk_en_o (en),
        .pclk_sel_o   (sel),
        .rate_req_i   (req),
        .rate_done_i  (done),
        .rate_ack_o   (ack),
        .rate_err_o   (err),
        .ready_o      (ready),
        .fault_o      (fault),
        .retry_cnt_o  (retry)
    );

    always @(negedge clk) if (ack) ack_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] probe(input int which);
        case (which)
            P_RSTN:  return {1'b0, rst_n};
            P_READY: return {1'b0, ready};
            P_EN:    return {1'b0, en};
            P_ACK:   return {1'b0, ack};
            P_FAULT: return {1'b0, fault};
            default: return sel;
        endcase
    endfunction

    // Ticks until the probed output equals val; n == bound means it never did.
    task automatic wait_for(input int which, input logic [1:0] val, input int bound, output int n);
        n = 0;
        while (probe(which) !== val && n < bound) begin
            tick();
            n++;
        end
    endtask

    function automatic int all_outs();
        return int'({rst_n, en, sel, ack, err, ready, fault, retry});
    endfunction

    task automatic do_rate(input bit tgt, input int dly, input bit tmo);
        int  n;
        int  a0;
        bit  old;
        old  = sel_m;
        a0   = ack_cnt;
        done = '0;
        req  = {LANES{tgt}};
        wait_for(P_EN, 2'b00, 5, n);
        chk("gate_off_lat", n, 1);
        chk("ready_drop", int'(ready), 0);
        wait_for(P_SEL, {LANES{tgt}}, GATE + 5, n);
        chk("gate_off_len", n, GATE);
        chk("en_at_switch", int'(en), 0);
        if (!tmo) begin
            repeat (dly) tick();
            done = '1;
            wait_for(P_ACK, 2'b01, GATE + 5, n);
            chk("ack_lat", n, GATE + 1);
            chk("sel_new", int'(sel), int'({LANES{tgt}}));
            chk("err_clear", int'(err), 0);
            sel_m = tgt;
        end else begin
            wait_for(P_SEL, {LANES{old}}, RTO + 5, n);
            chk("rate_tmo", n, RTO);
            chk("err_set", int'(err), 1);
            req = {LANES{old}};
            wait_for(P_ACK, 2'b01, GATE + 5, n);
            chk("ack_lat_tmo", n, GATE);
        end
        tick();
        done = '0;
        chk("ack_pulses", ack_cnt - a0, 1);
        chk("ack_low", int'(ack), 0);
        chk("en_back", int'(en), 1);
        chk("ready_back", int'(ready), 1);
    endtask

    task automatic mixed_req();
        int a0;
        a0  = ack_cnt;
        req = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        repeat (20) tick();
        chk("mixed_sel", int'(sel), int'({LANES{sel_m}}));
        chk("mixed_en", int'(en), 1);
        chk("mixed_ack", ack_cnt - a0, 0);
        req = {LANES{sel_m}};
    endtask

    initial begin
        int n;
        int r;
        int a0;

        // Reset and first clean lock
        repeat (3) tick();
        chk("reset_outs", all_outs(), 0);
        rst = 1'b0;
        wait_for(P_RSTN, 2'b01, 100, n);
        chk("rst_n_low", n, RST_C);
        chk("retry_first", int'(retry), 1);
        repeat (40) tick();
        lock = 1'b1;
        // 2 sync flops + 1 detect + LOCK_STABLE count + 1 registered output
        wait_for(P_READY, 2'b01, 500, n);
        chk("ready_lat", n, STAB + 4);
        chk("en_run", int'(en), 1);
        chk("retry_run", int'(retry), 1);

        // Rate changes: fixed cases then random ones
        sel_m = 1'b0;
        do_rate(1'b1, 100, 1'b0);
        do_rate(1'b0, $urandom_range(0, 200), 1'b0);
        mixed_req();
        do_rate(1'b1, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0) mixed_req();
            else        do_rate(~sel_m, $urandom_range(0, RTO - 20), r == 3);
        end
        chk("retry_hold", int'(retry), 1);

        // Lock glitch while stabilising, then lock loss mid-switch, then fault
        lock = 1'b0;
        req  = '0;
        done = '0;
        rst  = 1'b1;
        tick();
        rst   = 1'b0;
        sel_m = 1'b0;
        wait_for(P_RSTN, 2'b01, 100, n);
        chk("rst_n_low2", n, RST_C);
        repeat ($urandom_range(10, 60)) tick();
        lock = 1'b1;
        repeat ($urandom_range(5, 30)) tick();
        lock = 1'b0;
        tick();
        lock = 1'b1;
        chk("ready_pre_glitch", int'(ready), 0);
        wait_for(P_READY, 2'b01, 500, n);
        chk("ready_lat_glitch", n, STAB + 4);

        a0  = ack_cnt;
        req = 2'b11;
        wait_for(P_SEL, 2'b11, GATE + 10, n);
        repeat (5) tick();
        lock = 1'b0;
        wait_for(P_RSTN, 2'b00, 10, n);
        chk("loss_lat", n, 3);
        chk("loss_en", int'(en), 0);
        chk("loss_ready", int'(ready), 0);
        chk("loss_sel", int'(sel), 3);
        wait_for(P_RSTN, 2'b01, 100, n);
        chk("loss_rst_len", n, RST_C);
        chk("loss_retry", int'(retry), 2);
        // remaining attempt's wait, then one full attempt
        wait_for(P_FAULT, 2'b01, 2000, n);
        chk("fault_lat", n, LTO + (RST_C + LTO));
        chk("fault_retry", int'(retry), MAXR);
        chk("fault_rst_n", int'(rst_n), 0);
        chk("fault_en", int'(en), 0);
        chk("loss_no_ack", ack_cnt - a0, 0);
        req = '0;
        rst = 1'b1;
        #1;
        chk("rst_clear", all_outs(), 0);

        // Lock never arrives
        tick();
        rst = 1'b0;
        wait_for(P_FAULT, 2'b01, 4000, n);
        chk("fault_never", n, MAXR * (RST_C + LTO));
        chk("never_retry", int'(retry), MAXR);
        chk("never_outs", int'({rst_n, en, ready}), 0);
        rst = 1'b1;
        #1;
        chk("rst_clear2", all_outs(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
